// File: rtl/mul1024_seq_ctrl_pkg.sv
// Shared types and sizing for the 1024x1024 multiplier sequencer.
package mul1024_seq_ctrl_pkg;

  localparam int DEF_N       = 1024;
  localparam int DEF_W       = 32;
  localparam int DEF_TIMEOUT = 4096;

  localparam int WORDS_IN  = DEF_N / DEF_W;
  localparam int WORDS_OUT = 2 * DEF_N / DEF_W;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int KW = cnt_w(WORDS_IN);
  localparam int JW = cnt_w(WORDS_OUT);
  localparam int TW = cnt_w(DEF_TIMEOUT);

  typedef logic [2:0] state_t;

  localparam state_t S_LOAD_A = 3'd0;
  localparam state_t S_LOAD_B = 3'd1;
  localparam state_t S_START  = 3'd2;
  localparam state_t S_WAIT   = 3'd3;
  localparam state_t S_DRAIN  = 3'd4;

endpackage

// File: rtl/mul1024_word_shreg.sv
// Wide register with word-indexed write and full-width parallel load.
// Latency: write/load visible one cycle after the enabling edge.
// Backpressure: none; the owner gates wr_en/ld_en.
module mul1024_word_shreg #(
  parameter int WIDTH = 1024,
  parameter int W     = 32,
  parameter int IW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [W-1:0]     wr_data,
  input  logic             ld_en,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ld_en) begin
      q <= ld_data;
    end else if (wr_en) begin
      q[wr_idx*W +: W] <= wr_data;
    end
  end

endmodule

// File: rtl/mul1024_seq_ctrl.sv
// Sequencer: word-serial operand load, start pulse, done wait with timeout, word-serial product drain.
// Latency: last B word -> mul_start next cycle; mul_done -> out_valid next cycle.
// Backpressure: in_ready only in LOAD states; drain index holds while out_ready is low.
module mul1024_seq_ctrl
  import mul1024_seq_ctrl_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic           busy,
  output logic           err,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  output logic           mul_start,
  input  logic [2*N-1:0] mul_p,
  input  logic           mul_done
);

  localparam int WIN  = N / W;
  localparam int WOUT = 2 * N / W;
  localparam int KB   = cnt_w(WIN);
  localparam int JB   = cnt_w(WOUT);
  localparam int TB   = cnt_w(TIMEOUT);

  localparam logic [KB-1:0] K_LAST = KB'(WIN - 1);
  localparam logic [JB-1:0] J_LAST = JB'(WOUT - 1);
  localparam logic [TB-1:0] T_LAST = TB'(TIMEOUT - 1);

  state_t          state;
  logic [KB-1:0]   k;
  logic [JB-1:0]   j;
  logic [TB-1:0]   tcnt;
  logic            armed;
  logic [2*N-1:0]  prod;
  logic            in_xfer;
  logic            out_xfer;
  logic            a_wr;
  logic            b_wr;
  logic            p_ld;

  // armed keeps in_ready low for the first cycle out of reset
  assign in_ready  = armed && ((state == S_LOAD_A) || (state == S_LOAD_B));
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = (state == S_DRAIN);
  assign out_xfer  = out_valid && out_ready;
  assign out_last  = out_valid && (j == J_LAST);
  assign out_data  = prod[j*W +: W];
  assign mul_start = (state == S_START);
  assign busy      = !((state == S_LOAD_A) && (k == '0));

  assign a_wr = in_xfer && (state == S_LOAD_A);
  assign b_wr = in_xfer && (state == S_LOAD_B);
  assign p_ld = (state == S_WAIT) && mul_done;

  mul1024_word_shreg #(.WIDTH(N), .W(W), .IW(KB)) u_reg_a (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (a_wr),
    .wr_idx  (k),
    .wr_data (in_data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .q       (mul_a)
  );

  mul1024_word_shreg #(.WIDTH(N), .W(W), .IW(KB)) u_reg_b (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (b_wr),
    .wr_idx  (k),
    .wr_data (in_data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .q       (mul_b)
  );

  mul1024_word_shreg #(.WIDTH(2*N), .W(W), .IW(JB)) u_reg_p (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (1'b0),
    .wr_idx  ('0),
    .wr_data ('0),
    .ld_en   (p_ld),
    .ld_data (mul_p),
    .q       (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOAD_A;
      k     <= '0;
      j     <= '0;
      tcnt  <= '0;
      err   <= 1'b0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_LOAD_A: if (in_xfer) begin
          if (k == '0) err <= 1'b0;
          if (k == K_LAST) begin
            k     <= '0;
            state <= S_LOAD_B;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_LOAD_B: if (in_xfer) begin
          if (k == K_LAST) begin
            k     <= '0;
            state <= S_START;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_START: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            j     <= '0;
            state <= S_DRAIN;
          end else if (tcnt == T_LAST) begin
            // abort without producing output; operands stay until reloaded
            err   <= 1'b1;
            tcnt  <= '0;
            k     <= '0;
            state <= S_LOAD_A;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DRAIN: if (out_xfer) begin
          if (j == J_LAST) begin
            j     <= '0;
            state <= S_LOAD_A;
          end else begin
            j <= j + 1'b1;
          end
        end
        default: state <= S_LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_mul1024_seq_ctrl.sv
// Directed bench for mul1024_seq_ctrl with a behavioural multiplier model.
module tb_mul1024_seq_ctrl;

  localparam int N       = 1024;
  localparam int W       = 32;
  localparam int TIMEOUT = 4096;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           busy;
  logic           err;
  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic           mul_start;
  logic [2*N-1:0] mul_p;
  logic           mul_done;

  logic mdl_done;
  logic spur_done;
  bit   done_en;
  int   done_dly;
  int   done_len;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   start_cnt = 0;
  int   ov_seen = 0;

  logic [N-1:0] va;
  logic [N-1:0] vb;
  logic [N-1:0] vones;

  mul1024_seq_ctrl #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_start (mul_start),
    .mul_p     (mul_p),
    .mul_done  (mul_done)
  );

  always #5 clk = ~clk;

  assign mul_p    = {{N{1'b0}}, mul_a} * {{N{1'b0}}, mul_b};
  assign mul_done = mdl_done | spur_done;

  always @(negedge clk) begin
    if (!rst) begin
      if (mul_start) start_cnt++;
      if (out_valid) ov_seen++;
    end
  end

  initial begin
    mdl_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mul_start && done_en && !rst) begin
        repeat (done_dly) @(posedge clk);
        #1 mdl_done = 1'b1;
        repeat (done_len) @(posedge clk);
        #1 mdl_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    spur_done = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    step();
  endtask

  function automatic logic [31:0] exp_word(input int mode, input int j);
    if (mode == 0) return (j == 0) ? 32'd1452 : 32'd0;
    if (j == 0) return 32'd1;
    if (j < 32) return 32'd0;
    if (j == 32) return 32'hFFFF_FFFE;
    return 32'hFFFF_FFFF;
  endfunction

  task automatic load(input logic [N-1:0] a, input logic [N-1:0] b, input int nwords, input bit gaps);
    bit xfer;
    int guard;
    for (int idx = 0; idx < nwords; idx++) begin
      in_data  = (idx < 32) ? a[idx*32 +: 32] : b[(idx-32)*32 +: 32];
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      guard = 0;
      xfer  = 1'b0;
      while (!xfer && guard < 200) begin
        xfer = in_valid && in_ready;
        step();
        guard++;
        if (!xfer) in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (!xfer) check("load_timeout", 64'(idx), 64'hFFFF);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int mode, input bit bp);
    int  j;
    int  guard;
    bit  xfer;
    j = 0;
    guard = 0;
    while (j < 64 && guard < 3000) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      spur_done = bp ? 1'($urandom_range(0, 1)) : 1'b0;
      if (out_valid) begin
        check("out_data", 64'(out_data), 64'(exp_word(mode, j)));
        check("out_last", 64'(out_last), 64'(j == 63));
      end
      xfer = out_valid && out_ready;
      step();
      guard++;
      if (xfer) j++;
    end
    out_ready = 1'b0;
    spur_done = 1'b0;
    check("drain_words", 64'(j), 64'd64);
    check("drain_end_vld", 64'(out_valid), 64'd0);
    check("drain_end_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    int s0;
    int ov0;
    va = '0;
    vb = '0;
    va[7:0] = 8'd33;
    vb[7:0] = 8'd44;
    vones = '1;
    done_en  = 1'b1;
    done_dly = 5;
    done_len = 1;
    in_data  = '0;

    // reset state
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    spur_done = 1'b0;
    step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_start", 64'(mul_start), 64'd0);
    check("rst_mul_a", 64'(mul_a == '0), 64'd1);
    rst = 1'b0;
    step();
    step();
    check("in_ready_up", 64'(in_ready), 64'd1);

    // stray done in LOAD_A must not move the FSM
    spur_done = 1'b1;
    step();
    step();
    spur_done = 1'b0;
    check("spur_busy", 64'(busy), 64'd0);
    check("spur_vld", 64'(out_valid), 64'd0);
    check("spur_rdy", 64'(in_ready), 64'd1);

    // run 1: 33 x 44, junk in_valid during WAIT
    s0 = start_cnt;
    load(va, vb, 64, 1'b0);
    check("start_lat", 64'(mul_start), 64'd1);
    check("mul_a_33", 64'(mul_a == va), 64'd1);
    check("mul_b_44", 64'(mul_b == vb), 64'd1);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
      if (n == 1) check("start_pulse", 64'(mul_start), 64'd0);
      if (!out_valid) check("wait_rdy", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    check("done_lat", 64'(n), 64'd6);
    drain(0, 1'b0);
    check("start_once", 64'(start_cnt - s0), 64'd1);
    check("a_hold", 64'(mul_a == va), 64'd1);
    check("b_hold", 64'(mul_b == vb), 64'd1);

    // run 2: all-ones, input gaps, output backpressure, level done
    done_len = 3;
    s0 = start_cnt;
    load(vones, vones, 64, 1'b1);
    drain(1, 1'b1);
    check("start_once2", 64'(start_cnt - s0), 64'd1);
    done_len = 1;

    // timeout: no done at all
    done_en = 1'b0;
    ov0 = ov_seen;
    load(va, vb, 64, 1'b0);
    n = 0;
    while (!err && n < TIMEOUT + 100) begin
      step();
      n++;
      if (n == 100) check("err_early", 64'(err), 64'd0);
    end
    check("to_cycles", 64'(n), 64'(TIMEOUT + 1));
    check("to_err", 64'(err), 64'd1);
    check("to_busy", 64'(busy), 64'd0);
    check("to_rdy", 64'(in_ready), 64'd1);
    check("to_no_out", 64'(ov_seen - ov0), 64'd0);
    done_en = 1'b1;
    load(va, vb, 64, 1'b0);
    check("err_clear", 64'(err), 64'd0);
    drain(0, 1'b0);

    // reset during LOAD_B
    load(va, vb, 40, 1'b0);
    check("midb_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rstb_rdy", 64'(in_ready), 64'd0);
    check("rstb_busy", 64'(busy), 64'd0);
    check("rstb_mul_a", 64'(mul_a == '0), 64'd1);
    check("rstb_mul_b", 64'(mul_b == '0), 64'd1);
    do_reset();

    // reset during DRAIN
    load(va, vb, 64, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rstd_vld", 64'(out_valid), 64'd0);
    check("rstd_last", 64'(out_last), 64'd0);
    check("rstd_busy", 64'(busy), 64'd0);
    check("rstd_mul_a", 64'(mul_a == '0), 64'd1);
    do_reset();
    ov0 = ov_seen;
    repeat (5) step();
    check("post_rst_no_out", 64'(ov_seen - ov0), 64'd0);

    // clean run after resets
    load(va, vb, 64, 1'b1);
    drain(0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
